// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite ROM scheduler
package sprite_pkg;
  localparam int ROM_AW = 11;
  localparam int ORIENT_HI = 7;
  localparam int ORIENT_LO = 5;
  localparam int BMP_HI = 2;
  localparam int BMP_LO = 0;
  typedef enum logic [2:0] {
    RIGHT, DOWN, UP, LEFT, RIGHT_MIRROR, DOWN_MIRROR, UP_MIRROR, LEFT_MIRROR
  } orient_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/sprite_rom_sched_if.sv
// sprite_rom_sched_if: requester, ROM and return-path signals of the sprite ROM scheduler
interface sprite_rom_sched_if
  import sprite_pkg::*;
#(
  parameter int NREQ = 5,
  parameter int DW   = 4
);
  logic                en_i;
  logic [NREQ-1:0]     req_i;
  logic [8*NREQ-1:0]   sprite_i;
  logic [4*NREQ-1:0]   posx_i;
  logic [4*NREQ-1:0]   posy_i;
  logic [NREQ-1:0]     ack_o;
  logic                rom_en_o;
  logic [ROM_AW-1:0]   rom_addr_o;
  logic [DW-1:0]       rom_data_i;
  logic                rd_valid_o;
  logic [2:0]          rd_id_o;
  logic [DW-1:0]       rd_data_o;
  logic                busy_o;
  logic                done_o;
  modport master (
    output en_i, req_i, sprite_i, posx_i, posy_i, rom_data_i,
    input  ack_o, rom_en_o, rom_addr_o, rd_valid_o, rd_id_o, rd_data_o, busy_o, done_o
  );
  modport slave (
    input  en_i, req_i, sprite_i, posx_i, posy_i, rom_data_i,
    output ack_o, rom_en_o, rom_addr_o, rd_valid_o, rd_id_o, rd_data_o, busy_o, done_o
  );
endinterface

// File: rtl/sprite_orient_map.sv
// sprite_orient_map: orientation/mirror mapping of a tile pixel to a ROM address
module sprite_orient_map
  import sprite_pkg::*;
(
  input  logic [7:0]        sprite,
  input  logic [3:0]        posx,
  input  logic [3:0]        posy,
  output logic [ROM_AW-1:0] addr
);
  logic [2:0] b;
  logic [3:0] r, c;
  logic unused_bits;
  assign b = sprite[BMP_HI:BMP_LO];
  assign r = posy;
  assign c = posx;
  assign unused_bits = ^sprite[ORIENT_LO-1:BMP_HI+1];
  // choose row/column order and inversion from the orientation code
  always_comb begin
    case (orient_e'(sprite[ORIENT_HI:ORIENT_LO]))
      RIGHT:        addr = {b, r, ~c};
      DOWN:         addr = {b, c, r};
      UP:           addr = {b, c, ~r};
      LEFT:         addr = {b, r, c};
      RIGHT_MIRROR: addr = {b, ~r, ~c};
      DOWN_MIRROR:  addr = {b, ~c, r};
      UP_MIRROR:    addr = {b, ~c, ~r};
      default:      addr = {b, ~r, c};
    endcase
  end
endmodule

// File: rtl/sprite_rom_sched.sv
// sprite_rom_sched: round-robin sprite ROM arbiter with tagged read return and drain
module sprite_rom_sched
  import sprite_pkg::*;
#(
  parameter int NREQ    = 5,
  parameter int ROM_LAT = 1,
  parameter int DW      = 4
) (
  input logic px_clk,
  input logic rst_n,
  sprite_rom_sched_if.slave bus
);
  state_e                state;
  logic [2:0]            ptr, win;
  logic [3:0]            sum;
  logic                  hit, gnt;
  logic [NREQ-1:0]       elig, rot, oh;
  logic [ROM_LAT:0]      tv;
  logic [ROM_LAT:0][2:0] tid;
  logic [ROM_AW-1:0]     addr;

  sprite_orient_map u_map (
    .sprite(bus.sprite_i[{win, 3'b000} +: 8]),
    .posx  (bus.posx_i[{win, 2'b00} +: 4]),
    .posy  (bus.posy_i[{win, 2'b00} +: 4]),
    .addr  (addr)
  );

  // rotate eligibility so bit 0 is the pointer; lowest set bit wins, acked requester masked
  always_comb begin
    elig = bus.req_i & ~bus.ack_o;
    rot = NREQ'({elig, elig} >> ptr);
    hit = 1'b0;
    sum = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) begin
        hit = 1'b1;
        sum = {1'b0, ptr} + 4'(i);
      end
    win = sum >= 4'(NREQ) ? 3'(sum - 4'(NREQ)) : sum[2:0];
    gnt = state == RUN && bus.en_i && hit;
    oh = gnt ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
  end

  // window FSM, grant registers and the {valid,id} tag pipeline feeding the return path
  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      tv             <= '0;
      tid            <= '0;
      bus.ack_o      <= '0;
      bus.rom_en_o   <= 1'b0;
      bus.rom_addr_o <= '0;
      bus.rd_valid_o <= 1'b0;
      bus.rd_id_o    <= '0;
      bus.rd_data_o  <= '0;
      bus.done_o     <= 1'b0;
    end else begin
      state <= state == IDLE ? (bus.en_i ? RUN : IDLE) :
               state == RUN  ? (bus.en_i ? RUN : DRAIN) :
               (|tv ? DRAIN : IDLE);
      if (gnt) begin
        ptr            <= win == 3'(NREQ - 1) ? 3'd0 : win + 3'd1;
        bus.rom_addr_o <= addr;
      end
      tv             <= {tv[ROM_LAT-1:0], gnt};
      tid            <= {tid[ROM_LAT-1:0], win};
      bus.ack_o      <= oh;
      bus.rom_en_o   <= gnt;
      bus.rd_valid_o <= tv[ROM_LAT];
      bus.rd_id_o    <= tid[ROM_LAT];
      bus.rd_data_o  <= bus.rom_data_i;
      bus.done_o     <= state == DRAIN && !(|tv);
    end
  end

  assign bus.busy_o = state != IDLE || |tv;
endmodule

// File: tb/tb_sprite_rom_sched.sv
// tb_sprite_rom_sched: vectors, directed sequences and random traffic against a queue-based model
module tb_sprite_rom_sched;
  import sprite_pkg::*;
  localparam int NREQ = 5, ROM_LAT = 1, DW = 4;

  logic px_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 px_clk = ~px_clk;

  sprite_rom_sched_if #(.NREQ(NREQ), .DW(DW)) bus();
  sprite_rom_sched #(.NREQ(NREQ), .ROM_LAT(ROM_LAT), .DW(DW)) dut (
    .px_clk(px_clk), .rst_n(rst_n), .bus(bus)
  );

  // ROM: content is a fixed hash of the address, read latency ROM_LAT
  function automatic logic [DW-1:0] rom_fn(input logic [10:0] a);
    return a[3:0] ^ a[7:4] ^ {1'b0, a[10:8]} ^ 4'h5;
  endfunction
  logic [10:0] aq [ROM_LAT];
  always @(posedge px_clk) begin
    aq[0] <= bus.rom_addr_o;
    for (int k = 1; k < ROM_LAT; k++) aq[k] <= aq[k-1];
  end
  assign bus.rom_data_i = rom_fn(aq[ROM_LAT-1]);

  // address map straight from the orientation table
  function automatic logic [10:0] ref_map(input logic [7:0] s, input logic [3:0] c, input logic [3:0] r);
    logic [2:0] b;
    b = s[2:0];
    case (s[7:5])
      3'd0: return {b, r, ~c};
      3'd1: return {b, c, r};
      3'd2: return {b, c, ~r};
      3'd3: return {b, r, c};
      3'd4: return {b, ~r, ~c};
      3'd5: return {b, ~c, r};
      3'd6: return {b, ~c, ~r};
      default: return {b, ~r, c};
    endcase
  endfunction

  typedef struct {int due; int id; logic [DW-1:0] data;} ret_t;
  ret_t q[$];
  int m_mode, m_ptr, m_last, cyc;
  logic [10:0] m_addr;
  logic e_done;
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic new_fields(input int i);
    bus.sprite_i[8*i +: 8] = 8'($urandom);
    bus.posx_i[4*i +: 4] = 4'($urandom);
    bus.posy_i[4*i +: 4] = 4'($urandom);
  endtask

  // advance one cycle: model predicts from current inputs, then all outputs are compared
  task automatic step();
    int w, i;
    logic rs;
    logic [NREQ-1:0] ea;
    rs = rst_n;
    w = -1;
    if (!rs) begin
      m_mode = 0; m_ptr = 0; m_last = -1; m_addr = '0; e_done = 1'b0;
      q.delete();
    end else begin
      e_done = m_mode == 2 && q.size() == 0;
      if (m_mode == 1 && bus.en_i)
        for (int k = 0; k < NREQ; k++) begin
          i = (m_ptr + k) % NREQ;
          if (w < 0 && bus.req_i[i] && i != m_last) w = i;
        end
      m_mode = m_mode == 0 ? (bus.en_i ? 1 : 0) : m_mode == 1 ? (bus.en_i ? 1 : 2) : (q.size() == 0 ? 0 : 2);
      if (w >= 0) begin
        m_addr = ref_map(bus.sprite_i[8*w +: 8], bus.posx_i[4*w +: 4], bus.posy_i[4*w +: 4]);
        q.push_back('{cyc + ROM_LAT + 2, w, rom_fn(m_addr)});
        m_ptr = (w + 1) % NREQ;
      end
      m_last = w;
    end
    @(posedge px_clk);
    #1;
    cyc++;
    ea = '0;
    if (w >= 0) ea[w] = 1'b1;
    chk("ack", bus.ack_o, ea);
    chk("rom_en", bus.rom_en_o, w >= 0);
    chk("rom_addr", bus.rom_addr_o, m_addr);
    chk("done", bus.done_o, e_done);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rd_valid", bus.rd_valid_o, 1);
      chk("rd_id", bus.rd_id_o, q[0].id);
      chk("rd_data", bus.rd_data_o, q[0].data);
      void'(q.pop_front());
    end else chk("rd_valid", bus.rd_valid_o, 0);
    chk("busy", bus.busy_o, m_mode != 0 || q.size() > 0);
    if (!rs) begin
      chk("rst_id", bus.rd_id_o, 0);
      chk("rst_data", bus.rd_data_o, 0);
    end
  endtask

  typedef struct {logic [7:0] sprite; logic [3:0] px; logic [3:0] py; logic [10:0] addr;} vec_t;
  vec_t tbl [9];
  logic [10:0] sw [8] = '{11'h22E, 11'h212, 11'h21D, 11'h221, 11'h2DE, 11'h2E2, 11'h2ED, 11'h2D1};
  int na, nv, nd;

  initial begin
    tbl[0] = '{8'b000_00_101, 4'd3, 4'd9, 11'h59C};
    for (int k = 0; k < 8; k++) tbl[k+1] = '{{3'(k), 2'(k), 3'd2}, 4'd1, 4'd2, sw[k]};
    cyc = 0;
    bus.en_i = 1'b0; bus.req_i = '0; bus.sprite_i = '0; bus.posx_i = '0; bus.posy_i = '0;
    // reset state
    rst_n = 1'b0; step(); step();
    // single requester through every table vector
    rst_n = 1'b1; bus.en_i = 1'b1; step();
    for (int v = 0; v < 9; v++) begin
      bus.req_i = 5'b00001;
      bus.sprite_i[7:0] = tbl[v].sprite; bus.posx_i[3:0] = tbl[v].px; bus.posy_i[3:0] = tbl[v].py;
      step();
      chk("tbl_addr", bus.rom_addr_o, tbl[v].addr);
      chk("tbl_ack", bus.ack_o, 5'b00001);
      bus.req_i = '0;
      step();
    end
    step(); step();
    // all five held: strict round robin from requester 0
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    bus.req_i = '1;
    for (int i = 0; i < NREQ; i++) new_fields(i);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("rr_order", bus.ack_o, 32'(1) << (k % NREQ));
      if (m_last >= 0) new_fields(m_last);
    end
    // one requester held: grant every other cycle
    bus.req_i = '0; step(); step();
    bus.req_i[2] = 1'b1; new_fields(2);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("held_ack", bus.ack_o, (k % 2 == 0) ? 5'b00100 : 5'b00000);
      if (m_last == 2) new_fields(2);
    end
    // window closes with two reads in flight; en pulse during drain is ignored
    bus.req_i = '0; step(); step(); step();
    bus.req_i = 5'b00011; new_fields(0); new_fields(1);
    step();
    if (m_last >= 0) bus.req_i[m_last] = 1'b0;
    step();
    if (m_last >= 0) bus.req_i[m_last] = 1'b0;
    bus.en_i = 1'b0;
    na = 0; nv = 0; nd = 0;
    for (int j = 0; j < 6; j++) begin
      if (j == 1) begin bus.en_i = 1'b1; bus.req_i = 5'b10000; new_fields(4); end
      if (j == 2) begin bus.en_i = 1'b0; bus.req_i = '0; end
      step();
      na += (bus.ack_o != 0) ? 1 : 0;
      nv += bus.rd_valid_o ? 1 : 0;
      nd += bus.done_o ? 1 : 0;
    end
    chk("drain_acks", na, 0);
    chk("drain_valids", nv, 2);
    chk("drain_dones", nd, 1);
    chk("drain_busy", bus.busy_o, 0);
    // reset with a read in flight
    bus.en_i = 1'b1; step();
    bus.req_i = 5'b01000; new_fields(3); step();
    chk("pre_rst_en", bus.rom_en_o, 1);
    bus.req_i = '0; rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    chk("rst_discard", bus.rd_valid_o, 0);
    bus.req_i = '1;
    for (int i = 0; i < NREQ; i++) new_fields(i);
    step();
    chk("rst_ptr", bus.ack_o, 5'b00001);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(19) == 0) bus.en_i = ~bus.en_i;
      rst_n = $urandom_range(199) != 0;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_i[i] && m_last == i) begin
          if ($urandom_range(1) == 1) bus.req_i[i] = 1'b0;
          else new_fields(i);
        end else if (!bus.req_i[i] && $urandom_range(2) == 0) begin
          bus.req_i[i] = 1'b1;
          new_fields(i);
        end
      end
      step();
    end
    rst_n = 1'b1; bus.en_i = 1'b0; bus.req_i = '0;
    for (int n = 0; n < 10; n++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
